// File: rtl/i2s_audio_tx.sv
// I2S transmitter: pops one stereo pair per frame from FWFT audio FIFOs and
// serializes it MSB first with the standard one-bit delay after word select.
module i2s_audio_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int SCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] left_audio,
  input  logic [DATA_WIDTH-1:0] right_audio,
  input  logic                  left_out_empty,
  input  logic                  right_out_empty,
  output logic                  out_rd_en,
  output logic                  sclk,
  output logic                  ws,
  output logic                  sd,
  output logic [15:0]           underrun_cnt
);

  localparam int FRAME_BITS = 2 * DATA_WIDTH;
  localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int SLOT_W     = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(DATA_WIDTH);

  // TAIL sends the trailing right-LSB slot of the last frame before idling.
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_TAIL} state_t;

  state_t                  state_reg, state_next;
  logic [DIV_W-1:0]        div_reg;
  logic [SLOT_W-1:0]       slot_reg;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic                    sclk_reg, ws_reg, sd_reg;
  logic [15:0]             underrun_cnt_reg;

  logic                    div_wrap, slot_end, frame_end, both_ready;
  logic                    pop, underrun;
  logic [SLOT_W-1:0]       slot_inc;
  logic [DIV_W-1:0]        div_inc;

  assign div_wrap   = (div_reg == DIV_LAST);
  assign slot_end   = div_wrap && sclk_reg;
  assign frame_end  = (state_reg == S_RUN) && slot_end && (slot_reg == SLOT_LAST);
  assign both_ready = !left_out_empty && !right_out_empty;
  assign slot_inc   = slot_reg + SLOT_W'(1);
  assign div_inc    = div_reg + DIV_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    underrun   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable) state_next = S_PRIME;
      end
      S_PRIME: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (both_ready) begin
          pop        = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (frame_end) begin
          if (!enable)         state_next = S_TAIL;
          else if (both_ready) pop = 1'b1;
          else                 underrun = 1'b1;
        end
      end
      S_TAIL: begin
        if (slot_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The shift register's MSB is always the bit for the next slot, so the
  // right LSB naturally lands in slot 0 of the following frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg   <= '0;
      slot_reg  <= '0;
      shift_reg <= '0;
      sclk_reg  <= 1'b0;
      ws_reg    <= 1'b0;
      sd_reg    <= 1'b0;
    end else if (state_next == S_IDLE || state_next == S_PRIME) begin
      div_reg   <= '0;
      slot_reg  <= '0;
      shift_reg <= '0;
      sclk_reg  <= 1'b0;
      ws_reg    <= 1'b0;
      sd_reg    <= 1'b0;
    end else if (state_reg == S_PRIME) begin
      div_reg   <= '0;
      slot_reg  <= '0;
      shift_reg <= {left_audio, right_audio};
      sclk_reg  <= 1'b0;
      ws_reg    <= 1'b0;
      sd_reg    <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_reg  <= '0;
        sclk_reg <= !sclk_reg;
      end else begin
        div_reg  <= div_inc;
      end
      if (slot_end) begin
        sd_reg <= shift_reg[FRAME_BITS-1];
        if (slot_reg == SLOT_LAST) begin
          slot_reg  <= '0;
          ws_reg    <= 1'b0;
          shift_reg <= pop ? {left_audio, right_audio} : '0;
        end else begin
          slot_reg  <= slot_inc;
          ws_reg    <= (slot_inc >= SLOT_RIGHT);
          shift_reg <= shift_reg << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      underrun_cnt_reg <= '0;
    else if (underrun && underrun_cnt_reg != 16'hFFFF)
      underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
  end

  assign out_rd_en    = pop;
  assign sclk         = sclk_reg;
  assign ws           = ws_reg;
  assign sd           = sd_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: bench-side FWFT FIFOs feed the DUT and the
// serial stream is captured on every sclk rise for frame-level comparison.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] left_audio, right_audio;
  logic        left_out_empty, right_out_empty;
  logic        out_rd_en, sclk, ws, sd;
  logic [15:0] underrun_cnt;

  int total = 0;
  int bad   = 0;

  // bench FIFOs
  logic [31:0] lmem [0:63];
  logic [31:0] rmem [0:63];
  int lwr = 0, rwr = 0, lrd = 0, rrd = 0;
  logic fifo_clr = 1'b0;

  // observation records
  int   cyc = 0;
  logic sclk_q = 1'b0;
  logic prev_rd = 1'b0;
  int   dbl = 0;
  int   pop_n = 0;
  int   pop_t [0:63];
  int   cap_n = 0;
  logic cap_sd [0:4095];
  logic cap_ws [0:4095];
  int   cap_t  [0:4095];

  int base, p0;

  logic [31:0] sl [0:3] = '{32'h12345678, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h00000001};
  logic [31:0] sr [0:3] = '{32'h9ABCDEF1, 32'h00000000, 32'h5A5A5A5B, 32'h80000000};

  i2s_audio_tx #(.DATA_WIDTH(32), .SCLK_DIV(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .left_audio      (left_audio),
    .right_audio     (right_audio),
    .left_out_empty  (left_out_empty),
    .right_out_empty (right_out_empty),
    .out_rd_en       (out_rd_en),
    .sclk            (sclk),
    .ws              (ws),
    .sd              (sd),
    .underrun_cnt    (underrun_cnt)
  );

  always #5 clk = ~clk;

  assign left_audio      = lmem[lrd[5:0]];
  assign right_audio     = rmem[rrd[5:0]];
  assign left_out_empty  = (lrd >= lwr);
  assign right_out_empty = (rrd >= rwr);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    sclk_q  <= sclk;
    prev_rd <= out_rd_en;
    if (out_rd_en && prev_rd) dbl <= dbl + 1;
    if (fifo_clr) begin
      lrd <= lwr;
      rrd <= rwr;
    end else if (out_rd_en) begin
      lrd <= lrd + 1;
      rrd <= rrd + 1;
    end
    if (out_rd_en && pop_n < 64) begin
      pop_t[pop_n] <= cyc;
      pop_n        <= pop_n + 1;
    end
    if (sclk && !sclk_q && cap_n < 4096) begin
      cap_sd[cap_n] <= sd;
      cap_ws[cap_n] <= ws;
      cap_t[cap_n]  <= cyc;
      cap_n         <= cap_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cap(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && cap_n < target; i++) @(negedge clk);
    check(tag, 64'(cap_n), 64'(target));
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    lmem[lwr[5:0]] = l;
    lwr++;
    rmem[rwr[5:0]] = r;
    rwr++;
  endtask

  task automatic push_left(input logic [31:0] l);
    lmem[lwr[5:0]] = l;
    lwr++;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    fifo_clr = 1'b1;
    repeat (2) @(negedge clk);
    fifo_clr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Slot k of a frame: 0 = previous right LSB, 1..32 = left MSB..LSB,
  // 33..63 = right bits 31..1.
  function automatic logic [63:0] frame_bits(input logic [31:0] l, input logic [31:0] r,
                                             input logic p);
    logic [63:0] v;
    v[0] = p;
    for (int k = 1; k <= 32; k++) v[k] = l[32-k];
    for (int k = 33; k <= 63; k++) v[k] = r[64-k];
    return v;
  endfunction

  function automatic logic [63:0] cap_vec(input int b, input bit use_ws);
    logic [63:0] v;
    for (int k = 0; k < 64; k++) v[k] = use_ws ? cap_ws[b+k] : cap_sd[b+k];
    return v;
  endfunction

  initial begin
    logic [3:0] acc;
    logic       prev_lsb;

    // reset values, then 1000 quiet cycles with enable low
    repeat (3) @(negedge clk);
    check("reset_outputs", {43'd0, sclk, ws, sd, out_rd_en, underrun_cnt}, 64'd0);
    reset = 1'b1;
    acc = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      acc = acc | {sclk, ws, sd, out_rd_en};
    end
    check("idle_quiet", {60'd0, acc}, 64'd0);
    check("idle_no_pop_no_bits", {32'(pop_n), 32'(cap_n)}, 64'd0);

    // single frame
    base = cap_n; p0 = pop_n;
    push(32'h80000001, 32'h00000003);
    enable = 1'b1;
    wait_cap("single_reach", base + 65, 1000);
    check("single_pops", 64'(pop_n - p0), 64'd1);
    check("single_bits", cap_vec(base, 1'b0), 64'h8000_0001_0000_0002);
    check("single_next_slot0", {63'd0, cap_sd[base+64]}, 64'd1);
    check("single_ws", cap_vec(base, 1'b1), 64'hFFFF_FFFF_0000_0000);
    check("prime_latency", 64'(cap_t[base+1] - pop_t[p0]), 64'd13);
    check("single_underrun", {48'd0, underrun_cnt}, 64'd1);

    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 600 && !(sclk && ws); i++) @(negedge clk);
    check("midrun_active", {62'd0, sclk, ws}, 64'd3);
    reset = 1'b0;
    #1;
    check("midrun_reset", {43'd0, sclk, ws, sd, out_rd_en, underrun_cnt}, 64'd0);
    do_reset();

    // four pairs streamed back to back
    base = cap_n; p0 = pop_n;
    for (int i = 0; i < 4; i++) push(sl[i], sr[i]);
    enable = 1'b1;
    wait_cap("stream_reach", base + 256, 2500);
    check("stream_pops", 64'(pop_n - p0), 64'd4);
    check("stream_underrun", {48'd0, underrun_cnt}, 64'd0);
    wait_cap("stream_tail_reach", base + 257, 100);
    for (int i = 0; i < 3; i++)
      check($sformatf("stream_spacing%0d", i), 64'(pop_t[p0+i+1] - pop_t[p0+i]), 64'd512);
    prev_lsb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream_frame%0d", i), cap_vec(base + 64*i, 1'b0),
            frame_bits(sl[i], sr[i], prev_lsb));
      prev_lsb = sr[i][0];
    end
    check("stream_last_lsb", {63'd0, cap_sd[base+256]}, 64'd0);
    do_reset();

    // underrun after two pairs, then a left-only FIFO at the pop cycle
    base = cap_n; p0 = pop_n;
    push(32'h11111111, 32'h22222223);
    push(32'h33333333, 32'h44444445);
    enable = 1'b1;
    wait_cap("under_reach", base + 129, 1500);
    check("under_pops", 64'(pop_n - p0), 64'd2);
    check("under_cnt1", {48'd0, underrun_cnt}, 64'd1);
    push_left(32'h55555555);
    wait_cap("half_reach", base + 193, 700);
    check("under_frame1", cap_vec(base, 1'b0), frame_bits(32'h11111111, 32'h22222223, 1'b0));
    check("under_frame2", cap_vec(base + 64, 1'b0), frame_bits(32'h33333333, 32'h44444445, 1'b1));
    check("under_frame3_zero", cap_vec(base + 128, 1'b0), 64'd1);
    check("half_empty_pops", 64'(pop_n - p0), 64'd2);
    check("half_empty_cnt2", {48'd0, underrun_cnt}, 64'd2);
    do_reset();

    // enable dropped at slot 10 of frame 2
    base = cap_n; p0 = pop_n;
    push(32'hDEADBEEF, 32'hC0FFEE01);
    push(32'h0F0F0F0F, 32'hF0F0F0F1);
    push(32'h01234567, 32'h89ABCDEF);
    push(32'hFEDCBA98, 32'h76543210);
    enable = 1'b1;
    wait_cap("drop_reach", base + 74, 1500);
    enable = 1'b0;
    repeat (1500) @(negedge clk);
    check("drop_pops", 64'(pop_n - p0), 64'd2);
    check("drop_slots", 64'(cap_n - base), 64'd129);
    check("drop_frame2", cap_vec(base + 64, 1'b0), frame_bits(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b1));
    check("drop_tail_lsb", {62'd0, cap_sd[base+128], cap_ws[base+128]}, 64'd2);
    check("drop_idle_outputs", {60'd0, sclk, ws, sd, out_rd_en}, 64'd0);
    check("drop_underrun", {48'd0, underrun_cnt}, 64'd0);
    do_reset();

    // saturation: counter preloaded near the top, then more underruns
    base = cap_n; p0 = pop_n;
    push(32'hCAFEF00D, 32'h0BADBEEF);
    enable = 1'b1;
    wait_cap("sat_start", base + 10, 400);
    force dut.underrun_cnt_reg = 16'hFFFE;
    wait_cap("sat_first", base + 66, 700);
    release dut.underrun_cnt_reg;
    wait_cap("sat_second", base + 130, 700);
    check("sat_cnt_a", {48'd0, underrun_cnt}, 64'hFFFF);
    wait_cap("sat_third", base + 194, 700);
    check("sat_cnt_b", {48'd0, underrun_cnt}, 64'hFFFF);
    check("sat_pops", 64'(pop_n - p0), 64'd1);
    enable = 1'b0;

    check("no_double_pop", 64'(dbl), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
